// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding, opcode
// constants, ALU operation / operand-B select encodings and the datapath
// control bundle. The ALU control decoder imports the same alu_op_e values.
package multicycle_control_pkg;

  localparam int unsigned OPC_W   = 7;
  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXECUTE   = 4'd6,
    ST_ALU_WB    = 4'd7,
    ST_BRANCH    = 4'd8
  } state_e;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_B_REG     = 2'b00,
    SRC_B_FOUR    = 2'b01,
    SRC_B_IMM     = 2'b10,
    SRC_B_IMM_SH1 = 2'b11
  } alu_src_b_e;

  // Datapath control bundle driven by the output decoder.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       pc_source;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    logic       illegal_op;
  } ctrl_t;

  // True for the opcodes this controller knows how to sequence.
  function automatic logic opc_is_legal(input logic [OPC_W-1:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE) ||
           (opc == OPC_RTYPE) || (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RISC-V style control unit (Moore FSM) with retired-instruction
// counter.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   opcode[6:0]        instruction[6:0] from the instruction register
//   mem_ready          memory access complete this cycle
//   pc_write .. pc_source, alu_src_b[1:0], alu_op[1:0]   datapath controls
//   illegal_op         one-cycle pulse in DECODE on an unsupported opcode
//   state[3:0]         current state encoding (debug)
//   retired[CNT_W-1:0] completed-instruction count, wraps
//
// Build option: define MULTICYCLE_CTRL_MEM_WAIT_EN to honour mem_ready in
// FETCH / MEM_READ / MEM_WRITE. Without it, mem_ready is ignored and each
// memory state lasts exactly one cycle.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             i_or_d,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic             pc_source,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             mem_rdy;
  ctrl_t            ctrl;

  // Effective memory handshake; without wait support the port stays on the
  // interface but is forced ready.
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = mem_ready | 1'b1;
`endif

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic; retire marks a completing return to FETCH.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (mem_rdy) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (opcode)
          OPC_LOAD, OPC_STORE: state_d = ST_MEM_ADDR;
          OPC_RTYPE:           state_d = ST_EXECUTE;
          OPC_BRANCH:          state_d = ST_BRANCH;
          default:             state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR: begin
        state_d = (opcode == OPC_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
      end
      ST_MEM_READ: begin
        if (mem_rdy) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_MEM_WRITE: begin
        if (mem_rdy) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_ALU_WB;
      end
      ST_ALU_WB, ST_BRANCH: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Output decode from the current state; only the FETCH write strobes look
  // at mem_ready and only DECODE looks at the opcode.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.ir_write  = mem_rdy;
        ctrl.pc_write  = mem_rdy;
      end
      ST_DECODE: begin
        ctrl.alu_src_b  = SRC_B_IMM_SH1;
        ctrl.alu_op     = ALU_OP_ADD;
        ctrl.illegal_op = ~opc_is_legal(opcode);
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_ALU_WB: begin
        ctrl.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 1'b1;
      end
      default: begin
        ctrl = '0;
      end
    endcase
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign ir_write      = ctrl.ir_write;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign reg_write     = ctrl.reg_write;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign alu_src_a     = ctrl.alu_src_a;
  assign pc_source     = ctrl.pc_source;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign illegal_op    = ctrl.illegal_op;
  assign state         = state_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (counter width 4 so the wrap is
// reachable). Expected per-cycle output vectors are queued when an
// instruction is scheduled and compared as the DUT steps through it.
module tb_multicycle_control;

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                         S_MEM_READ = 4'd3, S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5,
                         S_EXECUTE = 4'd6, S_ALU_WB = 4'd7, S_BRANCH = 4'd8;
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_R = 7'b0110011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write;
  logic       i_or_d, mem_to_reg, alu_src_a, pc_source, illegal_op;
  logic [1:0] alu_src_b, alu_op;
  logic [3:0] state;
  logic [3:0] retired;
  logic [22:0] obs;

  multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .pc_source(pc_source), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  assign obs = {state, pc_write, pc_write_cond, ir_write, mem_read, mem_write,
                reg_write, i_or_d, mem_to_reg, alu_src_a, pc_source,
                alu_src_b, alu_op, illegal_op, retired};

  typedef struct {
    logic [6:0]  op;
    logic        rdy;
    logic [22:0] exp;
  } item_t;

  item_t      sb[$];
  item_t      it;
  logic [3:0] model_ret;
  int         n_pass = 0;
  int         n_total = 0;

  // Expected outputs for one cycle, straight from the state table.
  function automatic logic [22:0] exp_vec(input logic [3:0] st, input logic [6:0] op,
                                          input logic eff, input logic [3:0] ret);
    logic pcw, pcc, irw, mr, mw, rw, iod, m2r, sa, ps, ill;
    logic [1:0] sbs, ao;
    {pcw, pcc, irw, mr, mw, rw, iod, m2r, sa, ps, ill} = '0;
    sbs = 2'b00;
    ao  = 2'b00;
    case (st)
      S_FETCH:     begin mr = 1'b1; sbs = 2'b01; irw = eff; pcw = eff; end
      S_DECODE:    begin sbs = 2'b11;
                         ill = !(op == OP_LOAD || op == OP_STORE || op == OP_R || op == OP_BR); end
      S_MEM_ADDR:  begin sa = 1'b1; sbs = 2'b10; end
      S_MEM_READ:  begin mr = 1'b1; iod = 1'b1; end
      S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
      S_MEM_WRITE: begin mw = 1'b1; iod = 1'b1; end
      S_EXECUTE:   begin sa = 1'b1; ao = 2'b10; end
      S_ALU_WB:    begin rw = 1'b1; end
      S_BRANCH:    begin sa = 1'b1; ao = 2'b01; pcc = 1'b1; ps = 1'b1; end
      default:     ;
    endcase
    return {st, pcw, pcc, irw, mr, mw, rw, iod, m2r, sa, ps, sbs, ao, ill, ret};
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic void push_cycle(input logic [3:0] st, input logic [6:0] op, input logic rdy);
    item_t x;
    x.op  = op;
    x.rdy = rdy;
    x.exp = exp_vec(st, op, WAIT_EN ? rdy : 1'b1, model_ret);
    sb.push_back(x);
  endfunction

  // Schedule one instruction; waits = extra not-ready cycles in the memory
  // state, base = mem_ready level on the completing FETCH/memory cycle.
  function automatic void push_instr(input logic [6:0] op, input int waits, input logic base);
    push_cycle(S_FETCH, op, base);
    push_cycle(S_DECODE, op, rnd());
    case (op)
      OP_LOAD: begin
        push_cycle(S_MEM_ADDR, op, rnd());
        if (WAIT_EN) for (int i = 0; i < waits; i++) push_cycle(S_MEM_READ, op, 1'b0);
        push_cycle(S_MEM_READ, op, base);
        push_cycle(S_MEM_WB, op, rnd());
        model_ret = model_ret + 4'd1;
      end
      OP_STORE: begin
        push_cycle(S_MEM_ADDR, op, rnd());
        if (WAIT_EN) for (int i = 0; i < waits; i++) push_cycle(S_MEM_WRITE, op, 1'b0);
        push_cycle(S_MEM_WRITE, op, base);
        model_ret = model_ret + 4'd1;
      end
      OP_R: begin
        push_cycle(S_EXECUTE, op, rnd());
        push_cycle(S_ALU_WB, op, rnd());
        model_ret = model_ret + 4'd1;
      end
      OP_BR: begin
        push_cycle(S_BRANCH, op, rnd());
        model_ret = model_ret + 4'd1;
      end
      default: ;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; opcode = OP_R; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if ({state, retired, illegal_op, mem_read} !== {S_FETCH, 4'd0, 1'b0, 1'b1})
      $display("FAIL reset: state=%0d retired=%0d illegal=%b mem_read=%b, want 0 0 0 1",
               state, retired, illegal_op, mem_read);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_ret = 4'd0;
  endtask

  task automatic test_rtype();
    int k = 0;
    push_instr(OP_R, 0, 1'b1);
    push_instr(OP_R, 0, 1'b1);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      opcode = it.op; mem_ready = it.rdy; #1;
      n_total++;
      if (obs !== it.exp) $display("FAIL rtype cyc %0d: got %h want %h", k, obs, it.exp);
      else n_pass++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_load_wait();
    int k = 0;
    int rd_cycles = 0;
    push_instr(OP_LOAD, 3, 1'b1);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      opcode = it.op; mem_ready = it.rdy; #1;
      if (state == S_MEM_READ) rd_cycles++;
      n_total++;
      if (obs !== it.exp) $display("FAIL load_wait cyc %0d: got %h want %h", k, obs, it.exp);
      else n_pass++;
      k++;
      @(negedge clk);
    end
    n_total++;
    if (rd_cycles !== (WAIT_EN ? 4 : 1))
      $display("FAIL load_wait_read_cycles: got %0d want %0d", rd_cycles, WAIT_EN ? 4 : 1);
    else n_pass++;
  endtask

  task automatic test_store_branch();
    int k = 0;
    push_instr(OP_STORE, 0, 1'b1);
    push_instr(OP_BR, 0, 1'b1);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      opcode = it.op; mem_ready = it.rdy; #1;
      n_total++;
      if (obs !== it.exp) $display("FAIL store_branch cyc %0d: got %h want %h", k, obs, it.exp);
      else n_pass++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    int k = 0;
    push_instr(OP_BAD, 0, 1'b1);
    push_instr(OP_R, 0, 1'b1);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      opcode = it.op; mem_ready = it.rdy; #1;
      n_total++;
      if (obs !== it.exp) $display("FAIL illegal cyc %0d: got %h want %h", k, obs, it.exp);
      else n_pass++;
      k++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midop();
    push_instr(OP_STORE, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      it = sb.pop_front();
      opcode = it.op; mem_ready = it.rdy; #1;
      n_total++;
      if (obs !== it.exp) $display("FAIL midop_pre cyc %0d: got %h want %h", k, obs, it.exp);
      else n_pass++;
      @(negedge clk);
    end
    sb.delete();
    opcode = OP_STORE; mem_ready = 1'b0; rst = 1'b1; #1;
    n_total++;
    if ({state, mem_write} !== {S_MEM_WRITE, 1'b1})
      $display("FAIL midop_in_write: state=%0d mem_write=%b, want 5 1", state, mem_write);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if ({state, retired, mem_write, mem_read} !== {S_FETCH, 4'd0, 1'b0, 1'b1})
      $display("FAIL midop_reset: state=%0d retired=%0d mem_write=%b mem_read=%b, want 0 0 0 1",
               state, retired, mem_write, mem_read);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    model_ret = 4'd0;
  endtask

  // Sixteen R-types wrap the 4-bit counter to 0; then a load with mem_ready
  // held low in the default build (held high when waits are honoured).
  task automatic test_wrap_and_nowait_load();
    int k = 0;
    for (int i = 0; i < 16; i++) push_instr(OP_R, 0, 1'b1);
    push_instr(OP_LOAD, 0, WAIT_EN);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      opcode = it.op; mem_ready = it.rdy; #1;
      if (k == 64) begin
        n_total++;
        if ({state, retired} !== {S_FETCH, 4'd0})
          $display("FAIL wrap: state=%0d retired=%0d, want 0 0", state, retired);
        else n_pass++;
      end
      n_total++;
      if (obs !== it.exp) $display("FAIL wrap_load cyc %0d: got %h want %h", k, obs, it.exp);
      else n_pass++;
      k++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store_branch();
    test_illegal();
    test_reset_midop();
    test_wrap_and_nowait_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
